snake_game_ctrl: RTL

Game sequencer for the snake datapath. Owns the game-state FSM (IDLE / PLAY / GAME_OVER) and the step timer that issues the one-cycle `update` pulses moving the snake head. Filters button directions so the snake cannot reverse, and counts apples. Outputs `game_state`, `direction` and `update` drive the snake head block directly; `collision` comes back from the collision detector.

---
 rtl/snake_game_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game-state FSM, step timer, direction filter and apple scoring for the snake datapath.
module snake_game_ctrl #(
    parameter int FRAMES_PER_STEP = 6,
    parameter int OVER_FRAMES     = 120,
    parameter int SCORE_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic [2:0]         btn_dir,
    input  logic               btn_start,
    input  logic [1:0]         collision,
    output logic [1:0]         game_state,
    output logic [2:0]         direction,
    output logic               update,
    output logic [SCORE_W-1:0] score,
    output logic               apple_respawn
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] PLAY = 2'b01;
    localparam logic [1:0] OVER = 2'b11;
    localparam logic [2:0] UP = 3'd1, DOWN = 3'd2, LEFT = 3'd3, RIGHT = 3'd4;
    localparam int MAXF = FRAMES_PER_STEP > OVER_FRAMES ? FRAMES_PER_STEP : OVER_FRAMES;
    localparam int CW = $clog2(MAXF + 1);

    logic [CW-1:0] cnt;
    logic [2:0]    pending_dir;
    logic          apple_seen;
    logic          valid_dir;
    logic [2:0]    opp_dir;
    logic [2:0]    next_pend;
    logic          step_end;
    logic          over_end;
    logic          apple_rise;

    always_comb begin
        valid_dir  = btn_dir >= UP && btn_dir <= RIGHT;
        opp_dir    = direction == UP ? DOWN : direction == DOWN ? UP :
                     direction == LEFT ? RIGHT : direction == RIGHT ? LEFT : 3'd0;
        // reversal is judged against the committed heading, not the pending one
        next_pend  = (valid_dir && btn_dir != direction && btn_dir != opp_dir) ? btn_dir : pending_dir;
        step_end   = frame_start && cnt == CW'(FRAMES_PER_STEP - 1);
        over_end   = frame_start && cnt == CW'(OVER_FRAMES - 1);
        apple_rise = collision == 2'b10 && !apple_seen;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            game_state    <= IDLE;
            direction     <= 3'd0;
            update        <= 1'b0;
            score         <= '0;
            apple_respawn <= 1'b0;
            cnt           <= '0;
            pending_dir   <= 3'd0;
            apple_seen    <= 1'b0;
        end else begin
            update        <= 1'b0;
            apple_respawn <= 1'b0;
            apple_seen    <= collision == 2'b10;
            case (game_state)
                PLAY: begin
                    if (collision[0]) begin
                        game_state <= OVER;
                        cnt        <= '0;
                        direction  <= 3'd0;
                    end else begin
                        pending_dir <= next_pend;
                        if (frame_start) cnt <= step_end ? '0 : cnt + 1'b1;
                        if (step_end) begin
                            update    <= 1'b1;
                            direction <= next_pend;
                        end
                        if (apple_rise) begin
                            score         <= &score ? score : score + 1'b1;
                            apple_respawn <= 1'b1;
                        end
                    end
                end
                OVER: begin
                    if (over_end) begin
                        game_state  <= IDLE;
                        cnt         <= '0;
                        pending_dir <= 3'd0;
                    end else if (frame_start) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    direction <= 3'd0;
                    if (btn_start || valid_dir) begin
                        game_state  <= PLAY;
                        direction   <= valid_dir ? btn_dir : RIGHT;
                        pending_dir <= valid_dir ? btn_dir : RIGHT;
                        score       <= '0;
                        cnt         <= '0;
                    end
                end
            endcase
        end
    end
endmodule
